fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 32-bit combinational instruction ROM; owns the PC and drives the ROM address and output-enable.
- Presents each fetched instruction to the decode/execute stage with a valid/ready handshake.
- Applies branch redirects from execute.
- Halts on `wfi` (32'h10500073), on a misaligned PC, or on an out-of-range PC.

Parameters:
- L, 32, ROM depth in 32-bit words; ROM address width AW = $clog2(L).
- RESET_PC, 32'h0, byte address loaded on reset and on start.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins fetching at RESET_PC (accepted in IDLE or HALT)
- rom_addr  out  AW  ROM word index = pc[AW+1:2]
- rom_oe  out  1  ROM output enable
- rom_data  in  32  ROM read data (combinational, same cycle)
- instr  out  32  registered instruction
- instr_pc  out  32  byte address of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  consumer accepts instr this cycle
- branch_taken  in  1  sampled only on the accept cycle; redirect to branch_target
- branch_target  in  32  byte address of next instruction
- halted  out  1  high in HALT
- fault  out  1  high in HALT when the halt cause was a bad PC (sticky until start/reset)

Behaviour:
- States: IDLE, FETCH, ISSUE, HALT.
- Reset (synchronous, clk edge with reset=1) overrides everything, including mid-handshake:
  - state=IDLE, pc=RESET_PC, instr=32'h0, instr_pc=0.
  - instr_valid=0, rom_oe=0, halted=0, fault=0.
- rom_addr is always pc[AW+1:2]. rom_oe=1 only in FETCH.
- IDLE:
  - On start, go to FETCH with pc=RESET_PC; otherwise hold.
- FETCH (one cycle):
  - If pc[1:0]!=0 or pc>=4*L: HALT, fault=1, no ROM enable.
  - Otherwise rom_oe=1; instr<=rom_data, instr_pc<=pc; go to ISSUE.
- ISSUE:
  - instr_valid=1. instr, instr_pc and the state are held stable while instr_ready=0.
  - On instr_ready=1 (accept), evaluate in priority order:
    1. instr==32'h10500073: HALT, fault=0, pc unchanged.
    2. branch_taken: pc<=branch_target; go to FETCH.
    3. Otherwise: pc<=pc+4 (32-bit wrap; the range check catches overflow); go to FETCH.
  - instr_valid drops in the cycle after accept.
- Throughput: one instruction per 2 cycles when instr_ready is held high. Latency from start to first instr_valid: 2 cycles.
- HALT:
  - halted=1, instr_valid=0, rom_oe=0.
  - start: pc=RESET_PC, fault=0, go to FETCH.
  - branch_taken is ignored.
- start outside IDLE/HALT is ignored.
- A fetch at the last word (pc=4*(L-1)) is legal; the following sequential fetch faults.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- With the macro defined:
  - Adds output port `instr_count` (32 bits): the number of accepted instructions, including the `wfi` itself.
  - Cleared on reset and on start; saturates at 32'hFFFFFFFF.
  - Adds output `redirect_count` (16 bits): the number of accepts with branch_taken=1. Same clear and saturation rules.
- Without the macro: neither port nor either counter exists; behaviour is otherwise identical.

Decomposition:
- Package fetch_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, ISSUE, HALT);
  - localparam WFI_INSN=32'h10500073;
  - localparam PC_STEP=4.
- No sub-module: the PC register and next-PC mux stay inline, since the block is small and the FSM and PC update are tightly coupled.

Test Plan:
- Sequential fetch, L=32, ROM words 0..3 = 0x00000033, 0x00700113, 0x05002183, 0x10500073; start, instr_ready=1 → instr_pc 0,4,8,12 each valid for one cycle 2 cycles apart; halted=1, fault=0 after the 4th accept; rom_oe high only in FETCH cycles.
- Backpressure: hold instr_ready=0 for 5 cycles at instr_pc=4 → instr and instr_pc stable, valid held high, rom_oe=0, pc unchanged; release → next instr_pc=8.
- Branch: at accept of instr_pc=8, branch_taken=1, branch_target=0x0 → next instr_pc=0. Then branch_target=0x6 → HALT with fault=1. Then branch_target=0x80 with L=32 → fault=1.
- Boundary: branch to 0x7C (last word), accept without branch → next fetch faults; halted=1, fault=1, no ROM enable on the faulting cycle.
- Reset mid-handshake: assert reset while instr_valid=1 → next edge: instr_valid=0, state IDLE, pc=0. A start pulse then restarts the fetch from word 0. In HALT, start clears fault and resumes at RESET_PC.
- With FETCH_CTRL_PERF_EN: run the first scenario plus one taken branch → instr_count=5, redirect_count=1; start → both read 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_e;

   localparam logic [31:0] WFI_INSN = 32'h10500073;
   localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM, issues via valid/ready.
// Optional perf counters (instr_count, redirect_count) enabled by FETCH_CTRL_PERF_EN.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned  L        = 32,
   parameter logic [31:0]  RESET_PC = 32'h0,
   localparam int unsigned AW       = $clog2(L)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] rom_addr,
   output logic          rom_oe,
   input  logic [31:0]   rom_data,
   output logic [31:0]   instr,
   output logic [31:0]   instr_pc,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          branch_taken,
   input  logic [31:0]   branch_target,
`ifdef FETCH_CTRL_PERF_EN
   output logic [31:0]   instr_count,
   output logic [15:0]   redirect_count,
`endif
   output logic          halted,
   output logic          fault
);

   // 33-bit limit so very deep ROMs cannot wrap the comparison.
   localparam logic [32:0] PC_LIMIT = 33'(L) * 33'd4;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        fault_q, fault_d;
   logic        pc_bad;
   logic        accept;
   logic        restart;

   assign pc_bad  = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= PC_LIMIT);
   assign accept  = (state_q == ISSUE) && instr_ready;
   assign restart = start && ((state_q == IDLE) || (state_q == HALT));

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      fault_d    = fault_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               pc_d    = RESET_PC;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (pc_bad) begin
               fault_d = 1'b1;
               state_d = HALT;
            end else begin
               instr_d    = rom_data;
               instr_pc_d = pc_q;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
               if (instr_q == WFI_INSN) begin
                  fault_d = 1'b0;
                  state_d = HALT;
               end else if (branch_taken) begin
                  pc_d    = branch_target;
                  state_d = FETCH;
               end else begin
                  pc_d    = pc_q + PC_STEP;
                  state_d = FETCH;
               end
            end
         end
         HALT: begin
            if (start) begin
               pc_d    = RESET_PC;
               fault_d = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         fault_q    <= fault_d;
      end
   end

   assign rom_addr    = pc_q[AW+1:2];
   assign rom_oe      = (state_q == FETCH) && !pc_bad;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = (state_q == ISSUE);
   assign halted      = (state_q == HALT);
   assign fault       = fault_q;

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] instr_cnt_q, instr_cnt_d;
   logic [15:0] redir_cnt_q, redir_cnt_d;

   // Branch count follows the accept handshake, so a taken branch on a wfi accept still counts.
   always_comb begin
      instr_cnt_d = instr_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if (restart) begin
         instr_cnt_d = '0;
         redir_cnt_d = '0;
      end else if (accept) begin
         if (instr_cnt_q != '1) instr_cnt_d = instr_cnt_q + 32'd1;
         if (branch_taken && (redir_cnt_q != '1)) redir_cnt_d = redir_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign instr_count    = instr_cnt_q;
   assign redirect_count = redir_cnt_q;
`else
   logic unused_ok;
   assign unused_ok = restart | accept;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_ctrl;
   localparam int unsigned L  = 32;
   localparam int unsigned AW = 5;
   localparam logic [31:0] WFI = 32'h10500073;

   logic          clk = 1'b0;
   logic          reset, start, instr_ready, branch_taken;
   logic [31:0]   branch_target;
   logic [AW-1:0] rom_addr;
   logic          rom_oe, instr_valid, halted, fault;
   logic [31:0]   rom_data, instr, instr_pc;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0]   instr_count;
   logic [15:0]   redirect_count;
`endif

   logic [31:0] rom [0:L-1];
   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   fetch_ctrl #(.L(L), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rom_addr(rom_addr), .rom_oe(rom_oe), .rom_data(rom_data),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .branch_taken(branch_taken), .branch_target(branch_target),
`ifdef FETCH_CTRL_PERF_EN
      .instr_count(instr_count), .redirect_count(redirect_count),
`endif
      .halted(halted), .fault(fault)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: a "pending fetch" flag, a "held instruction" flag and a halted flag.
   logic [31:0] m_pc, m_instr, m_ipc;
   bit          m_fetching, m_holding, m_halted, m_fault;
   longint      m_ic, m_rc;

   function automatic bit pc_ok(input logic [31:0] pc);
      return (pc % 4 == 0) && (longint'(pc) < longint'(4 * L));
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_pc = 0; m_instr = 0; m_ipc = 0;
         m_fetching = 0; m_holding = 0; m_halted = 0; m_fault = 0;
         m_ic = 0; m_rc = 0;
      end else if (m_fetching) begin
         m_fetching = 0;
         if (pc_ok(m_pc)) begin
            m_instr = rom[m_pc / 4];
            m_ipc = m_pc;
            m_holding = 1;
         end else begin
            m_halted = 1;
            m_fault = 1;
         end
      end else if (m_holding) begin
         if (instr_ready) begin
            m_holding = 0;
            if (m_ic < 64'hFFFF_FFFF) m_ic++;
            if (branch_taken && m_rc < 64'hFFFF) m_rc++;
            if (m_instr == WFI) begin
               m_halted = 1;
               m_fault = 0;
            end else begin
               m_pc = branch_taken ? branch_target : m_pc + 32'd4;
               m_fetching = 1;
            end
         end
      end else if (start) begin
         m_pc = 0; m_fault = 0; m_halted = 0; m_fetching = 1;
         m_ic = 0; m_rc = 0;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         check("rom_addr", 32'(rom_addr), 32'(m_pc[AW+1:2]));
         check("rom_oe", 32'(rom_oe), 32'(m_fetching && pc_ok(m_pc)));
         check("instr_valid", 32'(instr_valid), 32'(m_holding));
         check("halted", 32'(halted), 32'(m_halted));
         check("fault", 32'(fault), 32'(m_fault));
         check("instr", instr, m_instr);
         check("instr_pc", instr_pc, m_ipc);
`ifdef FETCH_CTRL_PERF_EN
         check("instr_count", instr_count, 32'(m_ic));
         check("redirect_count", 32'(redirect_count), 32'(m_rc));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < int'(L); i++) begin
         rom[i] = $urandom;
         if ($urandom % 6 == 0) rom[i] = WFI;
      end
      rom[0] = 32'h00000033; rom[1] = 32'h00700113;
      rom[2] = 32'h05002183; rom[3] = WFI;
      rom[31] = 32'h00000013;

      reset = 1; start = 0; instr_ready = 0; branch_taken = 0; branch_target = 0;
      step(); step();
      reset = 0;
      step();
      check("pin_rst_valid", 32'(instr_valid), 32'd0);
      check("pin_rst_oe", 32'(rom_oe), 32'd0);
      check("pin_rst_halted", 32'(halted), 32'd0);

      // sequential fetch
      instr_ready = 1; start = 1;
      step(); start = 0;
      check("pin_fetch0_oe", 32'(rom_oe), 32'd1);
      step();
      check("pin_issue0_valid", 32'(instr_valid), 32'd1);
      check("pin_issue0_pc", instr_pc, 32'h0);
      check("pin_issue0_instr", instr, 32'h00000033);
      step(); step();
      check("pin_issue1_pc", instr_pc, 32'h4);
      // backpressure at instr_pc=4
      instr_ready = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("pin_bp_valid", 32'(instr_valid), 32'd1);
         check("pin_bp_pc", instr_pc, 32'h4);
         check("pin_bp_instr", instr, 32'h00700113);
         check("pin_bp_oe", 32'(rom_oe), 32'd0);
      end
      instr_ready = 1;
      step(); step();
      check("pin_issue2_pc", instr_pc, 32'h8);
      check("pin_issue2_instr", instr, 32'h05002183);
      step(); step();
      check("pin_issue3_instr", instr, WFI);
      step();
      check("pin_wfi_halted", 32'(halted), 32'd1);
      check("pin_wfi_fault", 32'(fault), 32'd0);

      // misaligned branch target
      start = 1; step(); start = 0; step();
      branch_taken = 1; branch_target = 32'h6;
      step(); branch_taken = 0;
      check("pin_misal_oe", 32'(rom_oe), 32'd0);
      step();
      check("pin_misal_halted", 32'(halted), 32'd1);
      check("pin_misal_fault", 32'(fault), 32'd1);

      // last legal word, then sequential overflow
      start = 1; step(); start = 0;
      check("pin_start_clears_fault", 32'(fault), 32'd0);
      step();
      branch_taken = 1; branch_target = 32'h7C;
      step(); branch_taken = 0;
      check("pin_last_oe", 32'(rom_oe), 32'd1);
      check("pin_last_addr", 32'(rom_addr), 32'd31);
      step();
      check("pin_last_pc", instr_pc, 32'h7C);
      step();
      check("pin_over_oe", 32'(rom_oe), 32'd0);
      step();
      check("pin_over_fault", 32'(fault), 32'd1);

      // reset mid-handshake
      start = 1; step(); start = 0; step();
      check("pin_mid_valid", 32'(instr_valid), 32'd1);
      reset = 1;
      step(); reset = 0;
      check("pin_mid_rst_valid", 32'(instr_valid), 32'd0);
      check("pin_mid_rst_fault", 32'(fault), 32'd0);
      start = 1; step(); start = 0; step();
      check("pin_restart_pc", instr_pc, 32'h0);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom % 100) == 0;
         start = ($urandom % 8) == 0;
         instr_ready = ($urandom % 4) != 0;
         branch_taken = ($urandom % 4) == 0;
         if ($urandom % 6 == 0) branch_target = $urandom_range(0, 255);
         else branch_target = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
